// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared joybus constants, command codes and host FSM encoding
//
// Purpose: command codes, reply lengths and bit-cell timing (in 2 MHz sample_clk
// ticks) used by the console host and the controller model, plus the host state
// encoding and a command-support helper.
package n64_pkg;

  // Command bytes understood by the host
  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  // Reply lengths in bits
  localparam logic [5:0] REPLY_LEN_INFO = 6'd24;
  localparam logic [5:0] REPLY_LEN_POLL = 6'd32;

  // Bit-cell timing in sample_clk ticks
  localparam int         TICKS_PER_BIT = 8;
  localparam logic [2:0] TICK_LAST     = 3'(TICKS_PER_BIT - 1);
  localparam logic [2:0] TICKS_SHORT   = 3'd2;
  localparam logic [2:0] TICKS_LONG    = 3'd6;
  localparam logic [2:0] SAMPLE_OFFSET = 3'd4;
  localparam logic [5:0] RESP_TIMEOUT  = 6'd32;
  localparam logic [3:0] CMD_BITS      = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_BIT    = 3'd1,
    ST_TX_STOP   = 3'd2,
    ST_RX_WAIT   = 3'd3,
    ST_RX_SAMPLE = 3'd4,
    ST_RX_STOP   = 3'd5
  } host_state_e;

  function automatic logic cmd_supported(input logic [7:0] c);
    return (c == CMD_INFO) || (c == CMD_POLL) || (c == CMD_RESET);
  endfunction

endpackage

// File: rtl/n64_edge_sync.sv
// rtl/n64_edge_sync.sv - two-flop synchroniser with falling/rising edge pulses
//
// Purpose: brings the asynchronous joybus line into the sample_clk domain and
// flags level transitions one cycle wide.
// Ports:
//   clk_i   in  1  sample clock
//   rst_i   in  1  synchronous active-high reset (line assumed idle high)
//   d_i     in  1  asynchronous line level
//   q_o     out 1  synchronised line level
//   fall_o  out 1  synchronised level went 1 -> 0 this cycle
//   rise_o  out 1  synchronised level went 0 -> 1 this cycle
module n64_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign fall_o = prev_q & ~sync_q;
  assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/n64_console_host.sv
// rtl/n64_console_host.sv - console-side joybus host: command serialiser and reply decoder
//
// Purpose: sends one command byte plus console stop bit on data_tx, then decodes
// the controller reply from data_rx into resp_data.
// Ports:
//   sample_clk  in  1   2 MHz clock, all logic on its rising edge
//   rst         in  1   synchronous active-high reset
//   cmd_valid   in  1   start request, ignored while busy or while resp_valid/err pulse
//   cmd         in  8   command byte (00/FF info, 01 poll)
//   data_rx     in  1   asynchronous line level from the controller, idle high
//   data_tx     out 1   host line drive, 1 = released, 0 = pulled low
//   busy        out 1   transaction in progress
//   resp_data   out 32  reply, first bit in the MSB of the reply length
//   resp_valid  out 1   one-cycle reply-ready pulse
//   err         out 1   one-cycle timeout / unsupported command pulse
module n64_console_host
  import n64_pkg::*;
(
  input  logic        sample_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd,
  input  logic        data_rx,
  output logic        data_tx,
  output logic        busy,
  output logic [31:0] resp_data,
  output logic        resp_valid,
  output logic        err
);

  host_state_e state_q, state_d;
  logic [7:0]  tx_sh_q, tx_sh_d;      // command bits still to send, MSB next
  logic [3:0]  bit_cnt_q, bit_cnt_d;  // command bits remaining
  logic [5:0]  rx_cnt_q, rx_cnt_d;    // reply bits taken
  logic [2:0]  tick_q, tick_d;
  logic [5:0]  tmo_q, tmo_d;
  logic        poll_q, poll_d;
  logic        stop_hi_q, stop_hi_d;  // RX_STOP: 0 = waiting for stop-bit fall, 1 = waiting for release
  logic [31:0] shift_q, shift_d;
  logic [31:0] resp_q, resp_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;

  logic        rx_lvl;
  logic        rx_fall;
  logic        rx_rise;
  logic [5:0]  tmo_inc;
  logic        tmo_hit;
  logic [2:0]  low_len;
  logic [5:0]  rx_len;
  logic [5:0]  rx_cnt_inc;

  n64_edge_sync u_rx_sync (
    .clk_i  (sample_clk),
    .rst_i  (rst),
    .d_i    (data_rx),
    .q_o    (rx_lvl),
    .fall_o (rx_fall),
    .rise_o (rx_rise)
  );

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    tick_d     = tick_q;
    tmo_d      = tmo_q;
    poll_d     = poll_q;
    stop_hi_d  = stop_hi_q;
    shift_d    = shift_q;
    resp_d     = resp_q;
    rv_d       = 1'b0;
    err_d      = 1'b0;
    data_tx    = 1'b1;
    tmo_inc    = tmo_q + 6'd1;
    tmo_hit    = (tmo_inc == RESP_TIMEOUT);
    low_len    = tx_sh_q[7] ? TICKS_SHORT : TICKS_LONG;
    rx_len     = poll_q ? REPLY_LEN_POLL : REPLY_LEN_INFO;
    rx_cnt_inc = rx_cnt_q + 6'd1;

    case (state_q)
      ST_IDLE: begin
        // A request landing on the completion pulse cycle is dropped.
        if (cmd_valid && !rv_q && !err_q) begin
          if (cmd_supported(cmd)) begin
            state_d   = ST_TX_BIT;
            tx_sh_d   = cmd;
            bit_cnt_d = CMD_BITS;
            tick_d    = 3'd0;
            poll_d    = (cmd == CMD_POLL);
            shift_d   = 32'd0;
            rx_cnt_d  = 6'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_TX_BIT: begin
        data_tx = (tick_q >= low_len);
        tick_d  = tick_q + 3'd1;
        if (tick_q == TICK_LAST) begin
          tx_sh_d   = {tx_sh_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd1) begin
            state_d = ST_TX_STOP;
          end
        end
      end

      ST_TX_STOP: begin
        data_tx = (tick_q >= TICKS_SHORT);
        tick_d  = tick_q + 3'd1;
        if (tick_q == TICKS_SHORT - 3'd1) begin
          state_d = ST_RX_WAIT;
          tick_d  = 3'd0;
          tmo_d   = 6'd0;
        end
      end

      ST_RX_WAIT: begin
        if (rx_fall) begin
          state_d = ST_RX_SAMPLE;
          tick_d  = 3'd0;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_RX_SAMPLE: begin
        tick_d = tick_q + 3'd1;
        if (tick_q == SAMPLE_OFFSET) begin
          shift_d  = {shift_q[30:0], rx_lvl};
          rx_cnt_d = rx_cnt_inc;
          tick_d   = 3'd0;
          tmo_d    = 6'd0;
          if (rx_cnt_inc == rx_len) begin
            state_d   = ST_RX_STOP;
            stop_hi_d = 1'b0;
          end else begin
            state_d = ST_RX_WAIT;
          end
        end
      end

      ST_RX_STOP: begin
        // The last data bit may still be low on entry, so only a rise that
        // follows the stop-bit fall completes the reply.
        if (!stop_hi_q && rx_fall) begin
          stop_hi_d = 1'b1;
          tmo_d     = 6'd0;
        end else if (stop_hi_q && rx_rise) begin
          state_d = ST_IDLE;
          resp_d  = shift_q;
          rv_d    = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= 8'd0;
      bit_cnt_q <= 4'd0;
      rx_cnt_q  <= 6'd0;
      tick_q    <= 3'd0;
      tmo_q     <= 6'd0;
      poll_q    <= 1'b0;
      stop_hi_q <= 1'b0;
      shift_q   <= 32'd0;
      resp_q    <= 32'd0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tick_q    <= tick_d;
      tmo_q     <= tmo_d;
      poll_q    <= poll_d;
      stop_hi_q <= stop_hi_d;
      shift_q   <= shift_d;
      resp_q    <= resp_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign resp_data  = resp_q;
  assign resp_valid = rv_q;
  assign err        = err_q;

endmodule
